// File: rtl/ss_pkg.sv
// Shared definitions for the map sequencer: map index constants and FSM state encoding.
package ss_pkg;

    localparam int unsigned MAP_W = 2;

    localparam logic [MAP_W-1:0] MAP_LR    = 2'd0;
    localparam logic [MAP_W-1:0] MAP_PART1 = 2'd1;
    localparam logic [MAP_W-1:0] MAP_LOOP  = 2'd2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REQ_FREEZE  = 3'd1,
        WAIT_VBLANK = 3'd2,
        SWITCH      = 3'd3,
        RELEASE     = 3'd4
    } ss_state_t;

endpackage

// File: rtl/ss_timeout_counter.sv
// Cycle counter for the freeze handshake.
// Ports: clk_75, reset (async active-low), clear (sync clear to 0),
//        enable (count one per cycle), expired_c (this cycle is the LIMIT-th enabled cycle).
module ss_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_75,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    // Counter holds 0 while cleared; the terminal count is LIMIT-1.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ss_map_sequencer.sv
// Map sequencer: detects the player entering a screen edge and switches the
// active map under a freeze handshake, committing the change on a vblank edge.
// Ports: clk_75, reset (async active-low), loc_x/loc_valid (player column),
//        vblank, freeze_ack (inputs); freeze_req, map_sel, map_changed,
//        busy, timeout_err (registered outputs).
module ss_map_sequencer
    import ss_pkg::*;
#(
    parameter logic [7:0]  RIGHT_EDGE  = 8'h7C,
    parameter logic [7:0]  LEFT_EDGE   = 8'h00,
    parameter int unsigned NUM_MAPS    = 3,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic             clk_75,
    input  logic             reset,
    input  logic [7:0]       loc_x,
    input  logic             loc_valid,
    input  logic             vblank,
    input  logic             freeze_ack,
    output logic             freeze_req,
    output logic [MAP_W-1:0] map_sel,
    output logic             map_changed,
    output logic             busy,
    output logic             timeout_err
);

    ss_state_t        state, state_d;
    logic [7:0]       prev_x;
    logic             vblank_q;
    logic [MAP_W-1:0] target, target_d;
    logic [MAP_W-1:0] map_sel_d;
    logic             map_changed_d, timeout_err_d, freeze_req_d, busy_d;
    logic             ev_right_c, ev_left_c, vblank_rise_c, expired_c;

    // Edge events fire only on entry to the edge column.
    assign ev_right_c    = loc_valid && (loc_x == RIGHT_EDGE) && (prev_x != RIGHT_EDGE);
    assign ev_left_c     = loc_valid && (loc_x == LEFT_EDGE)  && (prev_x != LEFT_EDGE);
    assign vblank_rise_c = vblank && !vblank_q;

    ss_timeout_counter #(.LIMIT(ACK_TIMEOUT)) u_timeout (
        .clk_75    (clk_75),
        .reset     (reset),
        .clear     (state != REQ_FREEZE),
        .enable    ((state == REQ_FREEZE) && !freeze_ack),
        .expired_c (expired_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev_x      <= 8'h00;
            vblank_q    <= 1'b0;
            target      <= MAP_LR;
            map_sel     <= MAP_LR;
            map_changed <= 1'b0;
            timeout_err <= 1'b0;
            freeze_req  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            vblank_q    <= vblank;
            target      <= target_d;
            map_sel     <= map_sel_d;
            map_changed <= map_changed_d;
            timeout_err <= timeout_err_d;
            freeze_req  <= freeze_req_d;
            busy        <= busy_d;
            if (loc_valid) begin
                prev_x <= loc_x;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state;
        target_d      = target;
        map_sel_d     = map_sel;
        map_changed_d = 1'b0;
        timeout_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (ev_right_c) begin
                    target_d = (map_sel == MAP_W'(NUM_MAPS - 1)) ? MAP_LR : map_sel + MAP_W'(1);
                    state_d  = REQ_FREEZE;
                end else if (ev_left_c && (map_sel != MAP_LR)) begin
                    target_d = map_sel - MAP_W'(1);
                    state_d  = REQ_FREEZE;
                end
            end
            REQ_FREEZE: begin
                if (freeze_ack) begin
                    state_d = WAIT_VBLANK;
                end else if (expired_c) begin
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end
            end
            WAIT_VBLANK: begin
                if (vblank_rise_c) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                map_sel_d     = target;
                map_changed_d = 1'b1;
                state_d       = RELEASE;
            end
            RELEASE: begin
                if (!freeze_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Freeze is held from REQ_FREEZE entry until RELEASE entry.
        freeze_req_d = (state_d == REQ_FREEZE) || (state_d == WAIT_VBLANK) || (state_d == SWITCH);
        busy_d       = (state_d != IDLE);
    end

endmodule
